// File: rtl/timetagger_stream_if.sv
// Byte-wide valid/ready stream carrying serialised time-tag records
// from the tagger to the UART byte transmitter.
interface timetagger_stream_if;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;

    modport master (
        output tx_data,
        output tx_valid,
        input  tx_ready
    );

    modport slave (
        input  tx_data,
        input  tx_valid,
        output tx_ready
    );
endinterface

// File: rtl/timetagger_stream.sv
// Parametrised time tagger: synchronises and edge-detects N strobe channels,
// stamps each hit cycle with a free-running timestamp, queues records in a
// small FIFO (with in-band drop markers on overflow) and streams them out
// MSB byte first over a valid/ready byte interface.
module timetagger_stream #(
    parameter int N_CHANNELS = 100,
    parameter int TS_WIDTH   = 43,
    parameter int FIFO_DEPTH = 16,
    parameter int DROP_WIDTH = 16
) (
    input  logic                          clk,
    input  logic                          reset_n,
    input  logic [N_CHANNELS-1:0]         strobe_channels,
    input  logic [N_CHANNELS-1:0]         channel_mask,
    input  logic                          activate,
    timetagger_stream_if.master           tx,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
    output logic                          overflow_flag,
    output logic                          busy
);

    localparam int REC_BITS  = 8 * ((1 + TS_WIDTH + N_CHANNELS + 7) / 8);
    localparam int REC_BYTES = REC_BITS / 8;
    localparam int AW        = $clog2(FIFO_DEPTH);
    localparam int BCW       = $clog2(REC_BYTES + 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_DRAIN
    } state_t;

    state_t                  state;
    state_t                  state_nxt;

    logic [N_CHANNELS-1:0]   sync_p0;
    logic [N_CHANNELS-1:0]   sync_p1;
    logic [N_CHANNELS-1:0]   sync_p2;
    logic [N_CHANNELS-1:0]   hit;

    logic [TS_WIDTH-1:0]     ts;
    logic [DROP_WIDTH-1:0]   drop_cnt;
    logic [DROP_WIDTH-1:0]   drop_nxt;
    logic                    ovf_set;
    logic                    run_start;

    logic [REC_BITS-1:0]     mem [FIFO_DEPTH];
    logic [AW-1:0]           wr_ptr;
    logic [AW-1:0]           rd_ptr;
    logic [AW:0]             count;
    logic                    fifo_full;
    logic                    fifo_empty;
    logic                    wr_en;
    logic [REC_BITS-1:0]     wr_rec;

    logic                    vld_p1;
    logic                    tx_valid_q;
    logic [REC_BITS-1:0]     shreg;
    logic [BCW-1:0]          byte_idx;
    logic                    ser_idle;
    logic                    pop;

    function automatic logic [DROP_WIDTH-1:0] sat_inc(input logic [DROP_WIDTH-1:0] v);
        return (&v) ? v : v + DROP_WIDTH'(1);
    endfunction

    function automatic logic [REC_BITS-1:0] event_rec(input logic [TS_WIDTH-1:0]   t,
                                                      input logic [N_CHANNELS-1:0] h);
        logic [REC_BITS-1:0] r;
        r = '0;
        r[TS_WIDTH+N_CHANNELS-1:N_CHANNELS] = t;
        r[N_CHANNELS-1:0] = h;
        return r;
    endfunction

    function automatic logic [REC_BITS-1:0] marker_rec(input logic [DROP_WIDTH-1:0] d);
        logic [REC_BITS-1:0] r;
        r = '0;
        r[REC_BITS-1] = 1'b1;
        r[DROP_WIDTH-1:0] = d;
        return r;
    endfunction

    assign hit        = sync_p1 & ~sync_p2 & channel_mask;
    assign fifo_full  = (count == (AW+1)'(FIFO_DEPTH));
    assign fifo_empty = (count == '0);
    assign ser_idle   = !vld_p1 && !tx_valid_q;
    assign pop        = ser_idle && !fifo_empty;

    assign fifo_level    = count;
    assign busy          = (state != ST_IDLE);
    assign tx.tx_valid   = tx_valid_q;
    assign tx.tx_data    = shreg[REC_BITS-1 -: 8];

    // Two-flop synchroniser plus a third flop holding the previous value for edge detection
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync_p0 <= '0;
            sync_p1 <= '0;
            sync_p2 <= '0;
        end else begin
            sync_p0 <= strobe_channels;
            sync_p1 <= sync_p0;
            sync_p2 <= sync_p1;
        end
    end

    // Acquisition state register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= ST_IDLE;
        else          state <= state_nxt;
    end

    // Next state and FIFO write decision; a pending drop marker beats a same-cycle hit
    always_comb begin
        state_nxt = state;
        run_start = 1'b0;
        wr_en     = 1'b0;
        wr_rec    = '0;
        drop_nxt  = drop_cnt;
        ovf_set   = 1'b0;

        case (state)
            ST_IDLE: begin
                if (activate) begin
                    state_nxt = ST_RUN;
                    run_start = 1'b1;
                end
            end
            ST_RUN: begin
                if (!activate) state_nxt = ST_DRAIN;
            end
            ST_DRAIN: begin
                if (fifo_empty && ser_idle && (drop_cnt == '0)) state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase

        if ((drop_cnt != '0) && !fifo_full) begin
            wr_en  = 1'b1;
            wr_rec = marker_rec(drop_cnt);
            if ((state == ST_RUN) && (hit != '0)) begin
                drop_nxt = DROP_WIDTH'(1);
                ovf_set  = 1'b1;
            end else begin
                drop_nxt = '0;
            end
        end else if ((state == ST_RUN) && (hit != '0)) begin
            if (!fifo_full) begin
                wr_en  = 1'b1;
                wr_rec = event_rec(ts, hit);
            end else begin
                drop_nxt = sat_inc(drop_cnt);
                ovf_set  = 1'b1;
            end
        end
    end

    // Timestamp, drop counter and sticky overflow flag; all restart when a run begins
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ts            <= '0;
            drop_cnt      <= '0;
            overflow_flag <= 1'b0;
        end else if (run_start) begin
            ts            <= '0;
            drop_cnt      <= '0;
            overflow_flag <= 1'b0;
        end else begin
            if (state != ST_IDLE) ts <= ts + TS_WIDTH'(1);
            drop_cnt <= drop_nxt;
            if (ovf_set) overflow_flag <= 1'b1;
        end
    end

    // Record storage; contents need no reset because pointers gate every read
    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_ptr] <= wr_rec;
    end

    // FIFO pointers and occupancy; a write and a pop in the same cycle cancel out
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (wr_en) wr_ptr <= wr_ptr + AW'(1);
            if (pop)   rd_ptr <= rd_ptr + AW'(1);
            count <= count + (AW+1)'(wr_en) - (AW+1)'(pop);
        end
    end

    // Serialiser: pop loads the shifter, valid follows a cycle later, one byte per handshake
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            vld_p1     <= 1'b0;
            tx_valid_q <= 1'b0;
            shreg      <= '0;
            byte_idx   <= '0;
        end else begin
            vld_p1 <= pop;
            if (pop) begin
                shreg <= mem[rd_ptr];
            end else if (vld_p1) begin
                tx_valid_q <= 1'b1;
                byte_idx   <= '0;
            end else if (tx_valid_q && tx.tx_ready) begin
                shreg <= shreg << 8;
                if (byte_idx == BCW'(REC_BYTES - 1)) begin
                    tx_valid_q <= 1'b0;
                end else begin
                    byte_idx <= byte_idx + BCW'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_timetagger_stream.sv
// Scoreboard bench for timetagger_stream in its small configuration
// (4 channels, 11-bit timestamp, 4-entry FIFO, 8-bit drop count => 16-bit records).
module tb_timetagger_stream;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic [3:0] strobe = 4'h0;
    logic [3:0] mask = 4'hF;
    logic       activate = 1'b0;
    logic [2:0] level;
    logic       ovf;
    logic       busy;

    int n_checks = 0;
    int n_fail   = 0;
    int rel      = 0;

    logic [7:0] exp_q[$];

    timetagger_stream_if tx_if ();

    timetagger_stream #(
        .N_CHANNELS(4),
        .TS_WIDTH  (11),
        .FIFO_DEPTH(4),
        .DROP_WIDTH(8)
    ) dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .strobe_channels(strobe),
        .channel_mask   (mask),
        .activate       (activate),
        .tx             (tx_if),
        .fifo_level     (level),
        .overflow_flag  (ovf),
        .busy           (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Monitor: pops the scoreboard on every accepted byte and checks hold-while-stalled
    logic       stall_q = 1'b0;
    logic [7:0] stall_data = 8'h00;
    always @(negedge clk) begin
        logic [7:0] e;
        if (!reset_n) begin
            stall_q = 1'b0;
        end else begin
            if (stall_q && tx_if.tx_valid) check("hold_stable", tx_if.tx_data, stall_data);
            if (tx_if.tx_valid && tx_if.tx_ready) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_byte: got 0x%02h, expected no byte", tx_if.tx_data);
                end else begin
                    e = exp_q.pop_front();
                    check("byte", tx_if.tx_data, e);
                end
            end
            stall_q    = tx_if.tx_valid && !tx_if.tx_ready;
            stall_data = tx_if.tx_data;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
        rel++;
    endtask

    task automatic tickn(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    // After this returns the design is in RUN with timestamp 0; rel counts edges from there
    task automatic start_run();
        activate = 1'b1;
        tick();
        rel = 1;
    endtask

    // One-cycle pulse whose record is written with timestamp t (mod 2048)
    task automatic pulse_ts(input int t, input logic [3:0] ch);
        while (rel < t - 1) tick();
        strobe = ch;
        tick();
        strobe = 4'h0;
    endtask

    task automatic push_rec(input logic [15:0] r);
        exp_q.push_back(r[15:8]);
        exp_q.push_back(r[7:0]);
    endtask

    task automatic wait_bytes(input int bound);
        int n = 0;
        while (exp_q.size() != 0 && n < bound) begin
            tick();
            n++;
        end
        check("bytes_delivered", exp_q.size(), 0);
    endtask

    task automatic stop_run(input int bound);
        int n = 0;
        activate = 1'b0;
        do begin
            tick();
            n++;
        end while (busy && n < bound);
        check("back_to_idle", busy, 1'b0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        tx_if.tx_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("rst_tx_valid", tx_if.tx_valid, 1'b0);
        check("rst_tx_data", tx_if.tx_data, 8'h00);
        check("rst_level", level, 3'd0);
        check("rst_ovf", ovf, 1'b0);
        check("rst_busy", busy, 1'b0);
        reset_n = 1'b1;
        tickn(2);

        // Basic event: ch1 written at timestamp 5 -> 0x0052
        mask = 4'hF;
        start_run();
        check("busy_run", busy, 1'b1);
        push_rec(16'h0052);
        pulse_ts(5, 4'b0010);
        tickn(2);
        check("level_after_write", level, 3'd1);
        tick();
        check("level_after_pop", level, 3'd0);
        wait_bytes(50);
        stop_run(50);

        // Mask: ch1 disabled; ch0+ch1 at timestamp 9 -> 0x0091
        mask = 4'b1101;
        start_run();
        push_rec(16'h0091);
        pulse_ts(3, 4'b0010);
        tickn(2);
        check("masked_no_write", level, 3'd0);
        pulse_ts(9, 4'b0011);
        wait_bytes(50);
        stop_run(50);

        // Overflow: 1 held in serialiser, 4 in FIFO, 2 dropped -> marker 0x8002
        mask = 4'hF;
        tx_if.tx_ready = 1'b0;
        start_run();
        push_rec(16'h0021);
        push_rec(16'h0041);
        push_rec(16'h0061);
        push_rec(16'h0081);
        push_rec(16'h00A1);
        push_rec(16'h8002);
        for (int t = 2; t <= 14; t += 2) pulse_ts(t, 4'b0001);
        tickn(2);
        check("ovf_level_full", level, 3'd4);
        check("ovf_flag_set", ovf, 1'b1);
        check("ovf_tx_valid_held", tx_if.tx_valid, 1'b1);
        tx_if.tx_ready = 1'b1;
        wait_bytes(200);
        check("ovf_flag_sticky", ovf, 1'b1);
        stop_run(50);

        // Wrap: ch2 at 2047, strobe low one cycle, next edge lands on timestamp 1
        start_run();
        check("ovf_cleared_on_run", ovf, 1'b0);
        push_rec(16'h7FF4);
        push_rec(16'h0014);
        pulse_ts(2047, 4'b0100);
        pulse_ts(2049, 4'b0100);
        wait_bytes(100);
        tickn(5);
        check("wrap_no_ovf", ovf, 1'b0);
        check("wrap_level", level, 3'd0);
        stop_run(50);

        // Drain: three records queued, ch3 strobed during DRAIN is discarded
        tx_if.tx_ready = 1'b0;
        start_run();
        push_rec(16'h0021);
        push_rec(16'h0041);
        push_rec(16'h0061);
        pulse_ts(2, 4'b0001);
        pulse_ts(4, 4'b0001);
        pulse_ts(6, 4'b0001);
        tickn(3);
        check("drain_level_before", level, 3'd2);
        activate = 1'b0;
        tick();
        check("drain_busy", busy, 1'b1);
        strobe = 4'b1000;
        tick();
        strobe = 4'h0;
        tickn(4);
        check("drain_ch3_discarded", level, 3'd2);
        tx_if.tx_ready = 1'b1;
        wait_bytes(100);
        check("drain_busy_until_last", busy, 1'b1);
        tick();
        check("drain_idle_after_last", busy, 1'b0);
        tickn(10);
        check("drain_no_more_bytes", tx_if.tx_valid, 1'b0);

        // Async reset in the middle of a stalled record
        tx_if.tx_ready = 1'b0;
        start_run();
        for (int t = 2; t <= 14; t += 2) pulse_ts(t, 4'b0001);
        tickn(2);
        check("pre_rst_ovf", ovf, 1'b1);
        check("pre_rst_tx_valid", tx_if.tx_valid, 1'b1);
        check("pre_rst_level", level, 3'd4);
        #2;
        reset_n  = 1'b0;
        activate = 1'b0;
        #1;
        check("arst_tx_valid", tx_if.tx_valid, 1'b0);
        check("arst_level", level, 3'd0);
        check("arst_ovf", ovf, 1'b0);
        check("arst_busy", busy, 1'b0);
        check("arst_tx_data", tx_if.tx_data, 8'h00);
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        tx_if.tx_ready = 1'b1;
        tickn(20);
        check("post_rst_busy", busy, 1'b0);
        check("post_rst_tx_valid", tx_if.tx_valid, 1'b0);
        check("post_rst_level", level, 3'd0);

        check("scoreboard_empty", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
